// File: rtl/alu_pipe_pkg.sv
// alu_pkg: opcode, FSM state and flag types shared by alu_pipe and its bench
package alu_pkg;
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL, ALU_SHL, ALU_SHR
   } alu_op_e;
   typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_e;
   typedef struct packed {
      logic zero;
      logic carry_out;
      logic overflow;
   } alu_flags_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between producer, alu_pipe and consumer
interface alu_pipe_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry_out;
   logic             overflow;
   logic             busy;
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry_out, overflow, busy
   );
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry_out, overflow, busy
   );
endinterface

// File: rtl/alu_pipe_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle
module alu_mul_seq #(parameter int WIDTH = 8) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   // product is the accumulator after the current step, so the final step is captured directly
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done = cnt == CW'(1);
   // latch operands on start, then add-and-shift once per cycle until the counter empties
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
      end else if (start) begin
         acc <= '0;
         mcand <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         acc <= product;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt - CW'(1);
      end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered handshaked ALU with sequential multiplier; ALU_PIPE_SAT_EN enables ADD/SUB saturation
module alu_pipe import alu_pkg::*; #(parameter int WIDTH = 8) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int M = WIDTH - 1;
   alu_state_e         state, state_n;
   alu_flags_t         flags, alu_f;
   logic [WIDTH-1:0]   result, alu_res, raw;
   logic [WIDTH:0]     sum, shl, shr;
   logic [2*WIDTH-1:0] product;
   logic [SHW-1:0]     sh;
   logic               sub, arith, accept, is_mul, mul_done;
   assign is_mul = bus.op == ALU_MUL;
   assign accept = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
   assign bus.out_valid = state == DONE;
   assign bus.busy = state == MUL;
   assign bus.result = result;
   assign bus.zero = flags.zero;
   assign bus.carry_out = flags.carry_out;
   assign bus.overflow = flags.overflow;
   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk(clk), .rst(rst), .start(accept && is_mul), .a(bus.a), .b(bus.b),
      .done(mul_done), .product(product)
   );
   // single-cycle datapath; shifts are widened by one bit so the shifted-out bit falls out for free
   always_comb begin
      sub = bus.op == ALU_SUB;
      arith = bus.op == ALU_ADD || sub;
      sh = bus.b[SHW-1:0];
      sum = {1'b0, bus.a} + {1'b0, sub ? ~bus.b : bus.b} + {{WIDTH{1'b0}}, sub};
      shl = {1'b0, bus.a} << sh;
      shr = {bus.a, 1'b0} >> sh;
      raw = arith ? sum[M:0] :
            bus.op == ALU_AND ? bus.a & bus.b :
            bus.op == ALU_OR  ? bus.a | bus.b :
            bus.op == ALU_XOR ? bus.a ^ bus.b :
            bus.op == ALU_SHL ? shl[M:0] : shr[WIDTH:1];
      alu_f.overflow = arith && (bus.a[M] ^ bus.b[M] ^ !sub) && (bus.a[M] ^ sum[M]);
      alu_f.carry_out = arith ? sum[WIDTH] : bus.op == ALU_SHL ? shl[WIDTH] : bus.op == ALU_SHR && shr[0];
`ifdef ALU_PIPE_SAT_EN
      alu_res = alu_f.overflow ? {bus.a[M], {M{!bus.a[M]}}} : raw;
`else
      alu_res = raw;
`endif
      alu_f.zero = alu_res == '0;
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   // next state: accept from IDLE or a draining DONE, multiply until the sequencer finishes
   always_comb begin
      state_n = state;
      if (accept) state_n = is_mul ? MUL : DONE;
      else if (state == MUL && mul_done) state_n = DONE;
      else if (state == DONE && bus.out_ready) state_n = IDLE;
   end
   // result/flag stage: single-cycle ops load on accept, multiplies on their last step
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         result <= '0;
         flags <= '0;
      end else if (accept && !is_mul) begin
         result <= alu_res;
         flags <= alu_f;
      end else if (state == MUL && mul_done) begin
         result <= product[M:0];
         flags <= {product[M:0] == '0, |product[2*WIDTH-1:WIDTH], 1'b0};
      end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with a scoreboard queue checked by an output monitor
module tb_alu_pipe;
   import alu_pkg::*;
   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
   } exp_t;
   logic clk = 0;
   logic rst = 1;
   int   passes = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t e;
   alu_pipe_if #(.WIDTH(8)) bus();
   alu_pipe #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endfunction

   function automatic exp_t mk(logic [7:0] r, logic z, logic c, logic v);
      exp_t x;
      x.res = r;
      x.z = z;
      x.c = c;
      x.v = v;
      return x;
   endfunction

   // presents one op at posedge+1, holds it until accepted, then drops in_valid
   task automatic send(logic [2:0] op, logic [7:0] a, logic [7:0] b, bit expect_out, exp_t ex,
                       output int waits);
      bus.op = op;
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1;
      if (expect_out) sb.push_back(ex);
      waits = 0;
      @(negedge clk);
      while (!bus.in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", waits, 0);
      @(posedge clk);
      #1 bus.in_valid = 0;
   endtask

   // monitor: every transfer must match the oldest expected result
   always @(negedge clk)
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("unexpected_output", sb.size(), 1);
         else begin
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("zero", bus.zero, e.z);
            chk("carry_out", bus.carry_out, e.c);
            chk("overflow", bus.overflow, e.v);
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.in_valid = 0;
      bus.a = 0;
      bus.b = 0;
      bus.op = 0;
      bus.out_ready = 0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_outputs", {bus.out_valid, bus.busy, bus.result, bus.zero, bus.carry_out, bus.overflow}, 0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1);
      bus.out_ready = 1;
      @(posedge clk);
      #1;
`ifdef ALU_PIPE_SAT_EN
      send(ALU_ADD, 8'h7F, 8'h01, 1, mk(8'h7F, 0, 0, 1), w);
`else
      send(ALU_ADD, 8'h7F, 8'h01, 1, mk(8'h80, 0, 0, 1), w);
`endif
      @(negedge clk);
      chk("add_latency", bus.out_valid, 1);
      @(posedge clk);
      #1;
      send(ALU_SUB, 8'h05, 8'h05, 1, mk(8'h00, 1, 1, 0), w);
      send(ALU_SUB, 8'h00, 8'h01, 1, mk(8'hFF, 0, 0, 0), w);
      send(ALU_MUL, 8'h10, 8'h11, 1, mk(8'h10, 0, 1, 0), w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mul_busy", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
      end
      @(negedge clk);
      chk("mul_latency", bus.out_valid, 1);
      @(posedge clk);
      #1;
      send(ALU_MUL, 8'h00, 8'hFF, 1, mk(8'h00, 1, 0, 0), w);
      send(ALU_SHL, 8'h81, 8'h01, 1, mk(8'h02, 0, 1, 0), w);
      send(ALU_SHR, 8'h81, 8'h00, 1, mk(8'h81, 0, 0, 0), w);
      @(posedge clk);
      #1 bus.out_ready = 0;
      send(ALU_AND, 8'hF0, 8'h3C, 1, mk(8'h30, 0, 0, 0), w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.carry_out, bus.overflow},
             {1'b1, 1'b0, 8'h30, 3'b000});
      end
      @(posedge clk);
      #1 bus.out_ready = 1;
      send(ALU_XOR, 8'hFF, 8'h0F, 1, mk(8'hF0, 0, 0, 0), w);
      chk("stream_stall0", w, 0);
      send(ALU_XOR, 8'hAA, 8'h55, 1, mk(8'hFF, 0, 0, 0), w);
      chk("stream_stall1", w, 0);
      send(ALU_XOR, 8'h3C, 8'h3C, 1, mk(8'h00, 1, 0, 0), w);
      chk("stream_stall2", w, 0);
      send(ALU_XOR, 8'h01, 8'h80, 1, mk(8'h81, 0, 0, 0), w);
      chk("stream_stall3", w, 0);
      @(negedge clk);
      chk("stream_last_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      send(ALU_MUL, 8'h10, 8'h11, 0, mk(8'h00, 0, 0, 0), w);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mul_busy_pre_rst", bus.busy, 1);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_outputs", {bus.out_valid, bus.busy, bus.result, bus.zero, bus.carry_out, bus.overflow}, 0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("post_rst_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
      @(posedge clk);
      #1;
      send(ALU_ADD, 8'h01, 8'h02, 1, mk(8'h03, 0, 0, 0), w);
      @(negedge clk);
      chk("post_rst_add_latency", bus.out_valid, 1);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
